// File: rtl/fifo_stream_adapter.sv
// Converts a 1-cycle-latency FIFO read port into a valid/ready stream master using a small skid buffer.
// Optional feature macro FIFO_STREAM_PARITY_EN adds a registered even-parity output m_parity.
module fifo_stream_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_STREAM_PARITY_EN
  ,
  output logic                  m_parity
`endif
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 2;

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  pop;
  logic                  capture;
  logic [CW-1:0]         credit;
`ifdef FIFO_STREAM_PARITY_EN
  logic                  par_q [BUF_DEPTH];
  logic                  par_d [BUF_DEPTH];
`endif

  assign m_valid = (occ_q != '0);
  assign m_data  = mem_q[rd_ptr_q];
`ifdef FIFO_STREAM_PARITY_EN
  assign m_parity = par_q[rd_ptr_q];
`endif

  always_comb begin
    pop     = m_valid & m_ready;
    capture = inflight_q & ~flush;
    // Entries held plus the word still on its way, less the one leaving now.
    credit    = CW'(occ_q) + CW'(inflight_q) - CW'(pop);
    fifo_r_en = rst & ~flush & ~fifo_empty & (credit < CW'(BUF_DEPTH));

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    inflight_d = fifo_r_en;
`ifdef FIFO_STREAM_PARITY_EN
    par_d = par_q;
`endif

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      occ_d      = '0;
      inflight_d = 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_d[i] = '0;
`ifdef FIFO_STREAM_PARITY_EN
        par_d[i] = 1'b0;
`endif
      end
    end else begin
      if (capture) begin
        mem_d[wr_ptr_q] = fifo_data;
`ifdef FIFO_STREAM_PARITY_EN
        par_d[wr_ptr_q] = ^fifo_data;
`endif
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      occ_d = occ_q + (PW+1)'(capture) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
`ifdef FIFO_STREAM_PARITY_EN
        par_q[i] <= 1'b0;
`endif
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
`ifdef FIFO_STREAM_PARITY_EN
        par_q[i] <= par_d[i];
`endif
      end
    end
  end

  // The read credit check should make a capture into a full, non-draining buffer impossible.
  overflow_a: assert property (@(posedge clk) disable iff (!rst)
    !(capture && !pop && occ_q == (PW+1)'(BUF_DEPTH)));

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter: queue-based FIFO and transfer reference model, per-scenario tasks.
`timescale 1ns/1ps
module tb_fifo_stream_adapter;
  localparam int DW = 8;
`ifdef FIFO_STREAM_PARITY_EN
  localparam int VW = DW + 3;
`else
  localparam int VW = DW + 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          fifo_empty;
  logic          fifo_r_en;
  logic [DW-1:0] fifo_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
`ifdef FIFO_STREAM_PARITY_EN
  logic          m_parity;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_stream_adapter #(.DATA_WIDTH(DW), .BUF_DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
`ifdef FIFO_STREAM_PARITY_EN
    .m_parity   (m_parity),
`endif
    .m_data     (m_data)
  );

  // Upstream FIFO: registered data out, one cycle after an accepted read.
  logic [DW-1:0] fifo_arr [1024];
  int fifo_head = 0;
  int fifo_tail = 0;
  assign fifo_empty = (fifo_head == fifo_tail);

  always @(posedge clk) begin
    if (fifo_r_en) begin
      fifo_data <= fifo_arr[fifo_head];
      fifo_head <= fifo_head + 1;
    end
  end

  task automatic push(input logic [DW-1:0] v);
    fifo_arr[fifo_tail] = v;
    fifo_tail++;
  endtask

  // Reference: every word read and not yet delivered, with the edge count at which it becomes visible.
  typedef struct {
    logic [DW-1:0] data;
    int            ready_at;
  } ent_t;
  ent_t ref_q[$];
  int   edge_cnt = 0;
  bit   ref_pop;

  function automatic bit exp_valid();
    if (ref_q.size() == 0) return 1'b0;
    return ref_q[0].ready_at <= edge_cnt;
  endfunction

  function automatic bit exp_r_en();
    int outstanding;
    outstanding = ref_q.size() - ((exp_valid() && m_ready) ? 1 : 0);
    return rst && !flush && !fifo_empty && (outstanding < 2);
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic          v;
    logic [DW-1:0] d;
    v = exp_valid();
    d = '0;
    if (v) d = ref_q[0].data;
`ifdef FIFO_STREAM_PARITY_EN
    return {exp_r_en(), v, d, v ? ^d : 1'b0};
`else
    return {exp_r_en(), v, d};
`endif
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    logic [DW-1:0] d;
    d = m_valid ? m_data : '0;
`ifdef FIFO_STREAM_PARITY_EN
    return {fifo_r_en, m_valid, d, m_valid ? m_parity : 1'b0};
`else
    return {fifo_r_en, m_valid, d};
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_q.delete();
    end else begin
      ref_pop = exp_valid() && m_ready;
      edge_cnt++;
      if (flush) begin
        ref_q.delete();
      end else begin
        if (ref_pop) void'(ref_q.pop_front());
        if (fifo_r_en) ref_q.push_back('{fifo_arr[fifo_head], edge_cnt + 1});
      end
    end
  end

  task automatic test_reset();
    #2 rst = 1'b0;
    push(8'hA5);
    @(negedge clk);
    n_cmp++;
    if ({fifo_r_en, m_valid, m_data} !== {1'b0, 1'b0, 8'h00}) begin
      n_err++; $display("FAIL reset r_en/valid/data: got %h want 000", {fifo_r_en, m_valid, m_data});
    end
`ifdef FIFO_STREAM_PARITY_EN
    n_cmp++;
    if (m_parity !== 1'b0) begin n_err++; $display("FAIL reset parity: got %b want 0", m_parity); end
`endif
  endtask

  task automatic test_basic();
    int ren_c = -1, val_c = -1, n_ren = 0, n_val = 0;
    logic [DW-1:0] vdata = '0;
    rst = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL basic c%0d: dut=%h ref=%h", c, dut_vec(), exp_vec()); end
      if (fifo_r_en) begin n_ren++; if (ren_c < 0) ren_c = c; end
      if (m_valid) begin n_val++; if (val_c < 0) val_c = c; vdata = m_data; end
      @(negedge clk);
    end
    n_cmp++;
    if (n_ren != 1 || n_val != 1 || val_c - ren_c != 2 || vdata !== 8'hA5) begin
      n_err++;
      $display("FAIL basic summary: r_en=%0d valid=%0d gap=%0d data=%h want 1 1 2 a5", n_ren, n_val, val_c - ren_c, vdata);
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] got[$];
    int first_c = -1, last_c = -1;
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    for (int c = 0; c < 14; c++) begin
      #1;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL stream c%0d: dut=%h ref=%h", c, dut_vec(), exp_vec()); end
      if (m_valid) begin
        got.push_back(m_data);
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (got.size() != 8 || last_c - first_c != 7) begin
      n_err++; $display("FAIL stream count: got %0d words over %0d cycles want 8 over 8", got.size(), last_c - first_c + 1);
    end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      n_cmp++;
      if (got[i] !== DW'(i + 1)) begin n_err++; $display("FAIL stream word%0d: got %h want %h", i, got[i], DW'(i + 1)); end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] got[$];
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(DW'(8'h10 + i));
    for (int c = 0; c < 10; c++) begin
      #1;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL bp_hold c%0d: dut=%h ref=%h", c, dut_vec(), exp_vec()); end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if ({fifo_r_en, m_valid, m_data} !== {1'b0, 1'b1, 8'h10} || ref_q.size() != 2) begin
      n_err++; $display("FAIL bp_full: got r_en/valid/data %h held %0d want 110 held 2", {fifo_r_en, m_valid, m_data}, ref_q.size());
    end
    @(negedge clk);
    m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL bp_drain c%0d: dut=%h ref=%h", c, dut_vec(), exp_vec()); end
      if (m_valid) got.push_back(m_data);
      @(negedge clk);
    end
    n_cmp++;
    if (got.size() != 4) begin n_err++; $display("FAIL bp_count: got %0d want 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      n_cmp++;
      if (got[i] !== DW'(8'h10 + i)) begin n_err++; $display("FAIL bp_word%0d: got %h want %h", i, got[i], DW'(8'h10 + i)); end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] sent[$];
    logic [DW-1:0] got[$];
    logic [DW-1:0] b;
    int c = 0;
    while (got.size() < 64 && c < 1000) begin
      if (sent.size() < 64 && $urandom_range(0, 2) != 0) begin
        b = DW'($urandom);
        push(b);
        sent.push_back(b);
      end
      m_ready = $urandom_range(0, 1) != 0;
      #1;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL random c%0d: dut=%h ref=%h", c, dut_vec(), exp_vec()); end
      n_cmp++;
      if (ref_q.size() > 2) begin n_err++; $display("FAIL random occupancy c%0d: got %0d want <=2", c, ref_q.size()); end
      if (m_valid && m_ready) got.push_back(m_data);
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (got.size() != 64) begin n_err++; $display("FAIL random count: got %0d want 64 (timeout)", got.size()); end
    for (int i = 0; i < got.size() && i < sent.size(); i++) begin
      n_cmp++;
      if (got[i] !== sent[i]) begin n_err++; $display("FAIL random word%0d: got %h want %h", i, got[i], sent[i]); end
    end
  endtask

  task automatic test_flush();
    logic [DW-1:0] got[$];
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(DW'(8'h20 + i));
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL flush_fill c%0d: dut=%h ref=%h", c, dut_vec(), exp_vec()); end
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    n_cmp++;
    if (fifo_r_en !== 1'b0) begin n_err++; $display("FAIL flush_no_read: got %b want 0", fifo_r_en); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_cmp++;
    if ({m_valid, fifo_r_en} !== 2'b01) begin n_err++; $display("FAIL flush_full_after: valid/r_en %b want 01", {m_valid, fifo_r_en}); end
`ifdef FIFO_STREAM_PARITY_EN
    n_cmp++;
    if (m_parity !== 1'b0) begin n_err++; $display("FAIL flush_parity: got %b want 0", m_parity); end
`endif
    @(negedge clk);
    flush = 1'b1;
    #1;
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL flush_inflight: dut=%h ref=%h", dut_vec(), exp_vec()); end
    @(negedge clk);
    flush = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 10 && got.size() < 2; c++) begin
      #1;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL flush_resume c%0d: dut=%h ref=%h", c, dut_vec(), exp_vec()); end
      if (m_valid) got.push_back(m_data);
      @(negedge clk);
    end
    n_cmp++;
    if (got.size() != 2 || got[0] !== 8'h23 || got[1] !== 8'h24) begin
      n_err++; $display("FAIL flush_order: got %0d words first %h want 2 words 23 24", got.size(), got.size() > 0 ? got[0] : 8'h00);
    end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] got[$];
    int start_idx, n_exp;
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) push(DW'(8'h30 + i));
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL arst_pre c%0d: dut=%h ref=%h", c, dut_vec(), exp_vec()); end
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({fifo_r_en, m_valid} !== 2'b00) begin n_err++; $display("FAIL arst_immediate: r_en/valid %b want 00", {fifo_r_en, m_valid}); end
    start_idx = fifo_head;
    n_exp = fifo_tail - fifo_head;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 60 && got.size() < n_exp; c++) begin
      #1;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL arst_post c%0d: dut=%h ref=%h", c, dut_vec(), exp_vec()); end
      if (m_valid && m_ready) got.push_back(m_data);
      @(negedge clk);
    end
    n_cmp++;
    if (got.size() != n_exp) begin n_err++; $display("FAIL arst_count: got %0d want %0d", got.size(), n_exp); end
    for (int i = 0; i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== fifo_arr[start_idx + i]) begin n_err++; $display("FAIL arst_word%0d: got %h want %h", i, got[i], fifo_arr[start_idx + i]); end
    end
  endtask

`ifdef FIFO_STREAM_PARITY_EN
  task automatic test_parity();
    logic pars[$];
    m_ready = 1'b1;
    push(8'h07);
    push(8'h03);
    for (int c = 0; c < 8; c++) begin
      #1;
      if (m_valid) pars.push_back(m_parity);
      @(negedge clk);
    end
    n_cmp++;
    if (pars.size() != 2 || pars[0] !== 1'b1 || pars[1] !== 1'b0) begin
      n_err++; $display("FAIL parity: got %0d values first %b want 2 values 1 0", pars.size(), pars.size() > 0 ? pars[0] : 1'b0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_backpressure();
    test_random();
    test_flush();
    test_async_reset();
`ifdef FIFO_STREAM_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

endmodule
